// File: rtl/fetch_pkg.sv
// Fetch stage shared types: FSM state, IF/ID payload, default reset PC.
// Latency: n/a (types and a helper only).
// Backpressure: n/a.
package fetch_pkg;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    FETCH  = 2'd1,
    HALTED = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] instr;
  } if_id_t;

  // Instruction fetches are word sized; only the two LSBs matter.
  function automatic logic is_word_aligned(input logic [1:0] addr_lsbs);
    return addr_lsbs == 2'b00;
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register with load, flush (valid-only clear) and hold.
// Latency: one cycle from load_i to if_id_o.
// Backpressure: holds contents whenever neither load_i nor flush_i is set.
module if_id_reg
  import fetch_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        load_i,
  input  logic        flush_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] instr_i,
  output if_id_t      if_id_o
);

  if_id_t if_id_q;
  if_id_t if_id_d;

  // Flush only drops valid so pc/instr keep their last captured values.
  always_comb begin
    if_id_d = if_id_q;
    if (flush_i) begin
      if_id_d.valid = 1'b0;
    end else if (load_i) begin
      if_id_d = '{valid: 1'b1, pc: pc_i, instr: instr_i};
    end
  end

  // Register stage; reset wipes the whole payload, not just valid.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      if_id_q <= '0;
    end else begin
      if_id_q <= if_id_d;
    end
  end

  assign if_id_o = if_id_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC sequencing, BOOT/FETCH/HALTED control, IF/ID capture.
// Latency: zero-latency imem read, instruction lands in IF/ID on the same edge.
// Backpressure: stall_i holds PC, IF/ID and count; optional FETCH_MISALIGN_CHECK_EN traps unaligned redirects.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int unsigned PC_STEP  = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        stall_i,
  input  logic        halt_i,
  input  logic        redirect_valid_i,
  input  logic [31:0] redirect_pc_i,
  output logic [31:0] imem_addr_o,
  input  logic [31:0] imem_instr_i,
  output logic        if_valid_o,
  output logic [31:0] if_pc_o,
  output logic [31:0] if_instr_o,
  output logic [31:0] fetch_cnt_o,
  output logic        misalign_o
);

  localparam logic [31:0] STEP = 32'(PC_STEP);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  cnt_q, cnt_d;
  logic         load;
  logic         flush;
  logic [31:0]  target;
  logic         bad_target;
  if_id_t       if_id;

`ifdef FETCH_MISALIGN_CHECK_EN
  logic misalign_q;
  logic misalign_set;

  assign target       = redirect_pc_i;
  assign bad_target   = !is_word_aligned(redirect_pc_i[1:0]);
  assign misalign_set = redirect_valid_i & bad_target;

  // Sticky trap flag: once an unaligned redirect is seen it stays until reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      misalign_q <= 1'b0;
    end else if (misalign_set) begin
      misalign_q <= 1'b1;
    end
  end

  assign misalign_o = misalign_q;
`else
  logic [1:0] unused_redirect_lsbs;

  assign unused_redirect_lsbs = redirect_pc_i[1:0];
  assign target               = {redirect_pc_i[31:2], 2'b00};
  assign bad_target           = 1'b0;
  assign misalign_o           = 1'b0;
`endif

  // Next-state decode: redirect beats everything, then stall, then halt.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    load    = 1'b0;
    flush   = 1'b0;
    if (redirect_valid_i) begin
      flush = 1'b1;
      if (bad_target) begin
        state_d = HALTED;
      end else begin
        pc_d    = target;
        state_d = FETCH;
      end
    end else begin
      case (state_q)
        BOOT: begin
          state_d = FETCH;
        end
        FETCH: begin
          if (!stall_i) begin
            if (halt_i) begin
              state_d = HALTED;
              flush   = 1'b1;
            end else begin
              load  = 1'b1;
              pc_d  = pc_q + STEP;
              cnt_d = cnt_q + 32'd1;
            end
          end
        end
        HALTED: begin
          state_d = HALTED;
        end
        default: begin
          state_d = BOOT;
        end
      endcase
    end
  end

  // Control and PC state; reset restarts in BOOT at RESET_PC.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
    end
  end

  if_id_reg u_if_id_reg (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .load_i  (load),
    .flush_i (flush),
    .pc_i    (pc_q),
    .instr_i (imem_instr_i),
    .if_id_o (if_id)
  );

  assign imem_addr_o = pc_q;
  assign if_valid_o  = if_id.valid;
  assign if_pc_o     = if_id.pc;
  assign if_instr_o  = if_id.instr;
  assign fetch_cnt_o = cnt_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios then randomized control against a cycle model.
// Latency: model advances once per rising edge, outputs compared on falling edges.
// Backpressure: stall/halt/redirect driven randomly; async resets injected mid-cycle.
module tb_fetch_unit;

  localparam logic [31:0] TB_RESET_PC = 32'h0000_0000;
  localparam int unsigned TB_STEP     = 4;
`ifdef FETCH_MISALIGN_CHECK_EN
  localparam bit MIS_EN = 1'b1;
`else
  localparam bit MIS_EN = 1'b0;
`endif

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        stall_i = 1'b0;
  logic        halt_i = 1'b0;
  logic        redirect_valid_i = 1'b0;
  logic [31:0] redirect_pc_i = '0;
  logic [31:0] imem_addr_o;
  logic [31:0] imem_instr_i;
  logic        if_valid_o;
  logic [31:0] if_pc_o;
  logic [31:0] if_instr_o;
  logic [31:0] fetch_cnt_o;
  logic        misalign_o;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state, expressed in terms of observable behaviour.
  bit          m_boot;
  bit          m_halted;
  logic [31:0] m_pc;
  logic        m_valid;
  logic [31:0] m_ipc;
  logic [31:0] m_instr;
  logic [31:0] m_cnt;
  logic        m_mis;

  fetch_unit #(
    .RESET_PC (TB_RESET_PC),
    .PC_STEP  (TB_STEP)
  ) dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .stall_i          (stall_i),
    .halt_i           (halt_i),
    .redirect_valid_i (redirect_valid_i),
    .redirect_pc_i    (redirect_pc_i),
    .imem_addr_o      (imem_addr_o),
    .imem_instr_i     (imem_instr_i),
    .if_valid_o       (if_valid_o),
    .if_pc_o          (if_pc_o),
    .if_instr_o       (if_instr_o),
    .fetch_cnt_o      (fetch_cnt_o),
    .misalign_o       (misalign_o)
  );

  always #5 clk_i = ~clk_i;

  // Instruction memory contents: a fixed scramble of the address; words 0 and 4 are NOPs.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0 || a == 32'h4) return 32'h0000_0013;
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  assign imem_instr_i = mem_word(imem_addr_o);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_boot   = 1'b1;
    m_halted = 1'b0;
    m_pc     = TB_RESET_PC;
    m_valid  = 1'b0;
    m_ipc    = '0;
    m_instr  = '0;
    m_cnt    = '0;
    m_mis    = 1'b0;
  endtask

  // One clock edge of architectural behaviour given the inputs held across it.
  task automatic model_step(input logic st, input logic hl, input logic rv, input logic [31:0] rp);
    if (rv) begin
      m_valid = 1'b0;
      m_boot  = 1'b0;
      if (MIS_EN && rp[1:0] != 2'b00) begin
        m_mis    = 1'b1;
        m_halted = 1'b1;
      end else begin
        m_pc     = MIS_EN ? rp : (rp & 32'hFFFF_FFFC);
        m_halted = 1'b0;
      end
    end else if (m_boot) begin
      m_boot = 1'b0;
    end else if (m_halted || st) begin
      // nothing moves
    end else if (hl) begin
      m_halted = 1'b1;
      m_valid  = 1'b0;
    end else begin
      m_valid = 1'b1;
      m_ipc   = m_pc;
      m_instr = mem_word(m_pc);
      m_pc    = m_pc + TB_STEP;
      m_cnt   = m_cnt + 1;
    end
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".addr"},  imem_addr_o, m_pc);
    check({tag, ".valid"}, {31'd0, if_valid_o}, {31'd0, m_valid});
    check({tag, ".pc"},    if_pc_o, m_ipc);
    check({tag, ".instr"}, if_instr_o, m_instr);
    check({tag, ".cnt"},   fetch_cnt_o, m_cnt);
    check({tag, ".mis"},   {31'd0, misalign_o}, {31'd0, m_mis});
  endtask

  // Called at a falling edge: drive inputs, take one rising edge, compare at the next falling edge.
  task automatic cycle(input string tag, input logic st, input logic hl, input logic rv,
                       input logic [31:0] rp);
    stall_i          = st;
    halt_i           = hl;
    redirect_valid_i = rv;
    redirect_pc_i    = rp;
    @(posedge clk_i);
    model_step(st, hl, rv, rp);
    @(negedge clk_i);
    compare_all(tag);
  endtask

  // Reset asserted between edges; outputs must clear before the next rising edge.
  task automatic async_reset(input string tag);
    #2 rst_i = 1'b1;
    #1;
    model_reset();
    compare_all({tag, ".async"});
    @(negedge clk_i);
    compare_all({tag, ".held"});
    stall_i          = 1'b0;
    halt_i           = 1'b0;
    redirect_valid_i = 1'b0;
    rst_i            = 1'b0;
  endtask

  initial begin
    model_reset();
    @(negedge clk_i);
    compare_all("reset");
    @(negedge clk_i);
    rst_i = 1'b0;

    // Boot bubble then two sequential captures of the NOP words.
    cycle("boot", 0, 0, 0, 0);
    check("boot_valid", {31'd0, if_valid_o}, 32'd0);
    cycle("cap0", 0, 0, 0, 0);
    check("cap0_pc", if_pc_o, 32'h0);
    check("cap0_instr", if_instr_o, 32'h0000_0013);
    cycle("cap4", 0, 0, 0, 0);
    check("cap4_pc", if_pc_o, 32'h4);
    check("cap4_cnt", fetch_cnt_o, 32'd2);

    // Three stalled cycles at PC 0x8, then capture on release.
    for (int i = 0; i < 3; i++) begin
      cycle("stall", 1, 0, 0, 0);
      check("stall_addr", imem_addr_o, 32'h8);
      check("stall_ifpc", if_pc_o, 32'h4);
    end
    cycle("unstall", 0, 0, 0, 0);
    check("unstall_pc", if_pc_o, 32'h8);

    // Redirect wins over stall, one bubble, then capture at the target.
    cycle("redir_stall", 1, 0, 1, 32'h100);
    check("redir_addr", imem_addr_o, 32'h100);
    check("redir_valid", {31'd0, if_valid_o}, 32'd0);
    cycle("redir_cap", 0, 0, 0, 0);
    check("redir_cap_pc", if_pc_o, 32'h100);

    // Halt at 0x20, sit for ten cycles, resume via redirect to 0x40.
    cycle("to20", 0, 0, 1, 32'h20);
    cycle("halt", 0, 1, 0, 0);
    for (int i = 0; i < 10; i++) begin
      cycle("halted", 0, 0, 0, 0);
      check("halted_addr", imem_addr_o, 32'h20);
    end
    cycle("resume", 0, 0, 1, 32'h40);
    cycle("resume_cap", 0, 0, 0, 0);
    check("resume_pc", if_pc_o, 32'h40);

    // Unaligned redirect: trapped when checking is built in, truncated otherwise.
    cycle("unaligned", 0, 0, 1, 32'h102);
    check("unaligned_addr", imem_addr_o, MIS_EN ? 32'h44 : 32'h100);
    check("unaligned_flag", {31'd0, misalign_o}, {31'd0, MIS_EN});
    cycle("unaligned_next", 0, 0, 0, 0);

    // Halt raised during a stall only takes effect once the stall drops.
    cycle("re200", 0, 0, 1, 32'h200);
    cycle("hs_stall", 1, 1, 0, 0);
    cycle("hs_go", 0, 1, 0, 0);
    cycle("hs_idle", 0, 0, 0, 0);
    check("hs_addr", imem_addr_o, 32'h200);

    // PC wraps past the top of the address space.
    cycle("to_top", 0, 0, 1, 32'hFFFF_FFFC);
    cycle("wrap", 0, 0, 0, 0);
    check("wrap_addr", imem_addr_o, 32'h0);
    check("wrap_ifpc", if_pc_o, 32'hFFFF_FFFC);

    // Async reset mid-fetch at PC 0x44, then a clean reboot.
    cycle("to40", 0, 0, 1, 32'h40);
    cycle("at44", 0, 0, 0, 0);
    check("at44_addr", imem_addr_o, 32'h44);
    async_reset("rst44");
    check("rst44_ifpc", if_pc_o, 32'h0);
    check("rst44_valid", {31'd0, if_valid_o}, 32'd0);
    cycle("reboot", 0, 0, 0, 0);
    check("reboot_valid", {31'd0, if_valid_o}, 32'd0);
    cycle("reboot_cap", 0, 0, 0, 0);
    check("reboot_pc", if_pc_o, TB_RESET_PC);

    // Randomized control traffic.
    for (int i = 0; i < 600; i++) begin
      logic        st, hl, rv;
      logic [31:0] rp;
      st = ($urandom_range(0, 3) == 0);
      hl = ($urandom_range(0, 19) == 0);
      rv = ($urandom_range(0, 11) == 0);
      rp = 32'($urandom_range(0, 255)) << 2;
      if ($urandom_range(0, 7) == 0) rp = rp | 32'($urandom_range(1, 3));
      if ($urandom_range(0, 15) == 0) rp = 32'hFFFF_FFF0;
      if ($urandom_range(0, 99) == 0) begin
        async_reset("rnd_rst");
      end else begin
        cycle("rnd", st, hl, rv, rp);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000: first fetch address after reset.
REQ-002 SHALL have parameter PC_STEP, default 4: PC increment per accepted fetch.
REQ-003 SHALL have port clk_i, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_i, input, 1 bit: reset, asynchronous and active-high.
REQ-005 SHALL have port stall_i, input, 1 bit: decode not ready; hold PC and IF/ID register.
REQ-006 SHALL have port halt_i, input, 1 bit: stop fetching after the current cycle.
REQ-007 SHALL have port redirect_valid_i, input, 1 bit: branch/jump/trap redirect request.
REQ-008 SHALL have port redirect_pc_i, input, 32 bits: redirect target byte address.
REQ-009 SHALL have port imem_addr_o, output, 32 bits: byte address driven to the instruction memory.
REQ-010 SHALL have port imem_instr_i, input, 32 bits: combinational read data from the instruction memory.
REQ-011 SHALL have port if_valid_o, output, 1 bit: IF/ID register holds a live instruction.
REQ-012 SHALL have port if_pc_o, output, 32 bits: PC of the IF/ID instruction.
REQ-013 SHALL have port if_instr_o, output, 32 bits: instruction word in IF/ID.
REQ-014 SHALL have port fetch_cnt_o, output, 32 bits: count of instructions captured into IF/ID.
REQ-015 SHALL have port misalign_o, output, 1 bit: sticky misaligned-redirect flag.

Function
REQ-016 SHALL drive imem_addr_o combinationally from pc_q; memory read is zero-latency, so capture occurs at the same edge.
REQ-017 SHALL implement FSM states BOOT, FETCH, HALTED.
REQ-018 BOOT SHALL last exactly one cycle after reset release with no capture, then move to FETCH.
REQ-019 In FETCH, with no redirect, no stall and no halt: IF/ID <= {valid=1, pc_q, imem_instr_i}; pc_q <= pc_q + PC_STEP; fetch_cnt_o increments.
REQ-020 In FETCH with stall_i=1 and no redirect: pc_q, IF/ID and fetch_cnt_o SHALL hold.
REQ-021 redirect_valid_i SHALL take priority over stall_i and halt_i in every state: pc_q <= target; if_valid_o <= 0 (one-bubble flush); next state FETCH.
REQ-022 In FETCH with halt_i=1, no redirect and no stall: go to HALTED, if_valid_o <= 0, pc_q held.
REQ-023 halt_i with stall_i=1 SHALL wait until the stall clears before halting.
REQ-024 HALTED SHALL hold all state and leave only on redirect_valid_i.
REQ-025 pc_q SHALL wrap modulo 2^32 with no flag.
REQ-026 fetch_cnt_o SHALL wrap from 32'hFFFF_FFFF to 0.
REQ-027 if_pc_o and if_instr_o SHALL hold their last values when if_valid_o=0.

Reset
REQ-028 On rst_i assertion, immediately and regardless of the clock, the block SHALL set: pc_q=RESET_PC, state=BOOT, if_valid_o=0, if_pc_o=0, if_instr_o=0, fetch_cnt_o=0, misalign_o=0.
REQ-029 Reset asserted mid-fetch or mid-stall SHALL discard the IF/ID contents with no partial update.

Configuration
REQ-030 With macro FETCH_MISALIGN_CHECK_EN defined, a redirect whose target[1:0]!=0 SHALL set misalign_o (sticky until reset), enter HALTED, leave pc_q unchanged and clear if_valid_o.
REQ-031 Without FETCH_MISALIGN_CHECK_EN, target[1:0] SHALL be forced to 2'b00 and misalign_o tied to 0.

Structure
REQ-032 Package fetch_pkg SHALL hold the FSM state enum (BOOT, FETCH, HALTED), the IF/ID struct {valid, pc, instr} and the default RESET_PC constant.
REQ-033 The IF/ID register SHALL be a sub-module if_id_reg (load, flush, hold); the FSM and PC logic stay in fetch_unit.

Verification
REQ-034 Reset release, no stalls, memory words 0x00000013 at addresses 0 and 4 -> cycle 1 if_valid_o=0; then if_pc_o=0, then if_pc_o=4; fetch_cnt_o=2.
REQ-035 stall_i high for 3 cycles at pc_q=0x8 -> imem_addr_o=0x8 and IF/ID unchanged for 3 cycles; capture of PC 0x8 on release.
REQ-036 redirect_valid_i=1 with stall_i=1 and redirect_pc_i=0x100 -> next cycle imem_addr_o=0x100 and if_valid_o=0; following capture if_pc_o=0x100.
REQ-037 halt_i pulse at pc_q=0x20 -> HALTED, imem_addr_o stays 0x20 for 10 cycles; redirect to 0x40 resumes with first capture at 0x40.
REQ-038 FETCH_MISALIGN_CHECK_EN defined, redirect to 0x102 -> misalign_o=1, HALTED, pc unchanged; undefined -> pc_q=0x100 and misalign_o=0.
REQ-039 rst_i asserted asynchronously between edges during FETCH at pc_q=0x44 -> outputs at reset values before the next edge; BOOT restarts at RESET_PC.
